// File: rtl/seq_sched_pkg.sv
// ============================================================================
// Module   : seq_sched_pkg
// Purpose  : Shared types and constants for the seq_scan_sched block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] PAT_RESET_DEF = 4'b1101;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/seq_match_engine.sv
// ============================================================================
// Module   : seq_match_engine
// Purpose  : Bit-serial pattern matcher: shift history, pattern register and
//            a warm-up qualifier so partial windows never report a match.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_match_engine
  import seq_sched_pkg::*;
#(
  parameter int               PAT_W     = 4,
  parameter logic [PAT_W-1:0] PAT_RESET = PAT_W'(PAT_RESET_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  output logic             m
);

  localparam int SEEN_W = $clog2(PAT_W);

  logic [PAT_W-2:0]  r_hist;
  logic [PAT_W-1:0]  r_pat;
  logic [SEEN_W-1:0] r_seen;
  logic [PAT_W-1:0]  w_window;
  logic              w_full;

  assign w_window = {r_hist, bit_in};
  // r_seen saturates at PAT_W-1: once that many bits precede the current one
  // the window is fully populated by the present word.
  assign w_full   = (r_seen == SEEN_W'(PAT_W - 1));
  assign m        = w_full && (w_window == r_pat);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist <= '0;
      r_seen <= '0;
      r_pat  <= PAT_RESET;
    end else begin
      if (pat_load) begin
        r_pat <= pat_in;
      end
      if (clr) begin
        r_hist <= '0;
        r_seen <= '0;
      end else if (shift_en) begin
        r_hist <= w_window[PAT_W-2:0];
        if (!w_full) begin
          r_seen <= r_seen + SEEN_W'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_scan_sched.sv
// ============================================================================
// Module   : seq_scan_sched
// Purpose  : Two-requester scheduler that serializes words LSB-first through
//            a shared pattern matcher and returns the per-word match count.
//            Optional macro SEQ_SCHED_RR_EN selects round-robin arbitration.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_scan_sched
  import seq_sched_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                PAT_W     = 4,
  parameter logic [PAT_W-1:0]  PAT_RESET = PAT_W'(PAT_RESET_DEF),
  localparam int               CNT_W     = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              pat_load,
  input  logic [PAT_W-1:0]  pat_in,
  output logic              busy,
  output logic              x_bit,
  output logic              y,
  output logic              done,
  output logic              done_id,
  output logic [CNT_W-1:0]  match_cnt
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_data;
  logic [IDX_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              r_owner;
  logic              r_last_grant;
  logic              w_grant;
  logic              w_hs;
  logic              w_bit;
  logic              w_last;
  logic              w_m;

  // Arbiter: decides who would win; only meaningful in IDLE.
`ifdef SEQ_SCHED_RR_EN
  always_comb begin
    w_grant = REQ0;
    if (req0_valid && req1_valid) begin
      w_grant = ~r_last_grant;
    end else if (req1_valid) begin
      w_grant = REQ1;
    end
  end
`else
  logic w_unused_last_grant;
  assign w_unused_last_grant = r_last_grant;

  always_comb begin
    w_grant = REQ0;
    if (!req0_valid && req1_valid) begin
      w_grant = REQ1;
    end
  end
`endif

  assign w_bit     = r_data[r_idx];
  assign w_last    = (r_idx == IDX_W'(DATA_W - 1));
  assign w_cnt_nxt = r_cnt + CNT_W'(w_m);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    busy        = 1'b0;
    w_hs        = 1'b0;
    case (r_state)
      IDLE: begin
        req0_ready = req0_valid && (w_grant == REQ0);
        req1_ready = req1_valid && (w_grant == REQ1);
        w_hs       = (req0_valid && (w_grant == REQ0)) ||
                     (req1_valid && (w_grant == REQ1));
        if (w_hs) begin
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        busy        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data       <= '0;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_owner      <= REQ0;
      r_last_grant <= REQ1;
      x_bit        <= 1'b0;
      y            <= 1'b0;
      done         <= 1'b0;
      done_id      <= REQ0;
      match_cnt    <= '0;
    end else begin
      done <= 1'b0;
      if (w_hs) begin
        r_data       <= (w_grant == REQ1) ? req1_data : req0_data;
        r_owner      <= w_grant;
        r_last_grant <= w_grant;
        r_idx        <= '0;
        r_cnt        <= '0;
      end
      if (r_state == SHIFT) begin
        x_bit <= w_bit;
        y     <= w_m;
        r_cnt <= w_cnt_nxt;
        r_idx <= r_idx + IDX_W'(1);
        if (w_last) begin
          done      <= 1'b1;
          match_cnt <= w_cnt_nxt;
          done_id   <= r_owner;
        end
      end
    end
  end

  // Pattern updates are only honoured while no word is in flight.
  seq_match_engine #(
    .PAT_W     (PAT_W),
    .PAT_RESET (PAT_RESET)
  ) u_engine (
    .clk      (clk),
    .rst      (rst),
    .clr      (w_hs),
    .shift_en (r_state == SHIFT),
    .bit_in   (w_bit),
    .pat_load (pat_load && (r_state == IDLE)),
    .pat_in   (pat_in),
    .m        (w_m)
  );

endmodule

`default_nettype wire

// File: tb/tb_seq_scan_sched.sv
// ============================================================================
// Module   : tb_seq_scan_sched
// Purpose  : Self-checking bench for seq_scan_sched against a word-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_scan_sched;

  localparam int DW = 8;
  localparam int PW = 4;
  localparam int CW = $clog2(DW + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          pat_load;
  logic [PW-1:0] pat_in;
  logic          busy, x_bit, y, done, done_id;
  logic [CW-1:0] match_cnt;

  int            n_total = 0;
  int            n_bad   = 0;
  logic [PW-1:0] m_pat;
  int            m_lastg;

  always #5 clk = ~clk;

  seq_scan_sched dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .pat_load   (pat_load),
    .pat_in     (pat_in),
    .busy       (busy),
    .x_bit      (x_bit),
    .y          (y),
    .done       (done),
    .done_id    (done_id),
    .match_cnt  (match_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Match after bit k: window of the last PW bits, oldest bit in the MSB.
  function automatic int model_y(logic [DW-1:0] d, logic [PW-1:0] p, int k);
    logic [PW-1:0] w;
    if (k < PW - 1) return 0;
    for (int i = 0; i < PW; i++) w[i] = d[k-i];
    return (w == p) ? 1 : 0;
  endfunction

  function automatic int model_cnt(logic [DW-1:0] d, logic [PW-1:0] p);
    int s = 0;
    for (int k = 0; k < DW; k++) s += model_y(d, p, k);
    return s;
  endfunction

  task automatic run_word(input int who, input logic [DW-1:0] d, input logic do_load,
                          input logic [PW-1:0] p, input int noise, output int waits);
    int   t;
    int   ey;
    int   ecnt;
    logic rdy;
    @(negedge clk);
    if (who == 0) begin req0_valid = 1'b1; req0_data = d; end
    else          begin req1_valid = 1'b1; req1_data = d; end
    if (do_load) begin pat_load = 1'b1; pat_in = p; end
    #1;
    t   = 0;
    rdy = (who == 0) ? req0_ready : req1_ready;
    while (!rdy && t < 40) begin
      @(negedge clk); #1;
      t++;
      rdy = (who == 0) ? req0_ready : req1_ready;
    end
    waits = t;
    if (!rdy) begin
      chk("hs_timeout", 0, 1);
      req0_valid = 1'b0; req1_valid = 1'b0; pat_load = 1'b0;
      return;
    end
    if (do_load) m_pat = p;
    m_lastg = who;
    @(posedge clk); #1;
    // keep both requesters asking so that ready-while-busy would show
    req0_valid = 1'b1; req1_valid = 1'b1; pat_load = 1'b0;
    chk("busy_after_hs", busy, 1);
    ecnt = 0;
    for (int k = 0; k < DW; k++) begin
      @(posedge clk); @(negedge clk);
      ey   = model_y(d, m_pat, k);
      ecnt += ey;
      chk("x_bit", x_bit, d[k]);
      chk("y", y, ey);
      chk("busy_shift", busy, 1);
      chk("ready_busy", {req0_ready, req1_ready}, 0);
      chk("done_strobe", done, (k == DW - 1) ? 1 : 0);
      if (k == DW - 1) begin
        chk("match_cnt", match_cnt, ecnt);
        chk("done_id", done_id, who);
      end
      if (noise == 1) begin
        pat_load = 1'b1; pat_in = '0;
      end else if (noise == 2) begin
        pat_load = 1'($urandom_range(0, 1)); pat_in = PW'($urandom);
      end
    end
    @(posedge clk); @(negedge clk);
    pat_load = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    chk("done_clear", done, 0);
    chk("busy_clear", busy, 0);
    chk("cnt_hold", match_cnt, ecnt);
  endtask

  task automatic arb_test();
    logic [DW-1:0] w0[3];
    logic [DW-1:0] w1[3];
    int n0 = 0, n1 = 0, budget = 0, exp_w, got_w;
    int q_id[$];
    int q_cnt[$];
    for (int i = 0; i < 3; i++) begin w0[i] = DW'($urandom); w1[i] = DW'($urandom); end
    @(negedge clk);
    while ((n0 < 3 || n1 < 3 || q_id.size() > 0) && budget < 300) begin
      budget++;
      if (done) begin
        if (q_id.size() == 0) chk("spurious_done", 1, 0);
        else begin
          chk("arb_done_id", done_id, q_id.pop_front());
          chk("arb_cnt", match_cnt, q_cnt.pop_front());
        end
      end
      req0_valid = (n0 < 3); if (n0 < 3) req0_data = w0[n0];
      req1_valid = (n1 < 3); if (n1 < 3) req1_data = w1[n1];
      #1;
      got_w = -1;
      if (req0_ready) got_w = 0;
      else if (req1_ready) got_w = 1;
      if (busy) chk("arb_ready_busy", {req0_ready, req1_ready}, 0);
      else if (n0 < 3 || n1 < 3) begin
`ifdef SEQ_SCHED_RR_EN
        if (n0 < 3 && n1 < 3) exp_w = (m_lastg == 1) ? 0 : 1;
`else
        if (n0 < 3 && n1 < 3) exp_w = 0;
`endif
        else exp_w = (n0 < 3) ? 0 : 1;
        chk("arb_grant", got_w, exp_w);
        chk("arb_one_ready", req0_ready & req1_ready, 0);
      end
      @(posedge clk);
      if (got_w == 0) begin
        q_id.push_back(0); q_cnt.push_back(model_cnt(w0[n0], m_pat)); n0++; m_lastg = 0;
      end else if (got_w == 1) begin
        q_id.push_back(1); q_cnt.push_back(model_cnt(w1[n1], m_pat)); n1++; m_lastg = 1;
      end
      @(negedge clk);
    end
    if (budget >= 300) chk("arb_timeout", 0, 1);
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int dcount;
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b0; req0_data = '0; req1_data = '0;
    pat_load = 1'b0; pat_in = '0;
    m_pat = 4'b1101; m_lastg = 1;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_x_bit", x_bit, 0);
    chk("rst_y", y, 0);
    chk("rst_done", done, 0);
    chk("rst_done_id", done_id, 0);
    chk("rst_match_cnt", match_cnt, 0);
    chk("rst_ready0", {req0_ready, req1_ready}, 2'b10);
    req0_valid = 1'b0; req1_valid = 1'b1; #1;
    chk("rst_ready1", {req0_ready, req1_ready}, 2'b01);
    req1_valid = 1'b0;
    @(negedge clk); rst = 1'b0;

    run_word(0, 8'b1011_0110, 1'b0, '0, 0, w);          // default pattern, two hits
    run_word(1, 8'hFF, 1'b1, 4'b1111, 0, w);            // overlapping matches
    run_word(0, 8'h00, 1'b1, 4'b1101, 0, w);            // no matches
    run_word(0, 8'b1011_0110, 1'b0, '0, 1, w);          // loads during SHIFT ignored
    run_word(1, 8'b0110_1101, 1'b0, '0, 0, w);

    arb_test();

    for (int i = 0; i < 30; i++) begin
      run_word(int'($urandom_range(0, 1)), DW'($urandom), ($urandom_range(0, 2) == 0),
               PW'($urandom), 2, w);
    end
    arb_test();

    // reset in the middle of a word
    run_word(1, 8'hFF, 1'b1, 4'b1111, 0, w);
    @(negedge clk);
    req0_valid = 1'b1; req0_data = DW'($urandom);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_x_bit", x_bit, 0);
    chk("mid_rst_y", y, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_done_id", done_id, 0);
    chk("mid_rst_match_cnt", match_cnt, 0);
    m_pat = 4'b1101; m_lastg = 1;
    @(negedge clk); rst = 1'b0;
    dcount = 0;
    repeat (12) begin @(negedge clk); if (done) dcount++; end
    chk("no_done_after_rst", dcount, 0);
    run_word(0, DW'($urandom), 1'b0, '0, 0, w);
    chk("first_valid_accept", w, 0);
    run_word(0, 8'b1101_1101, 1'b0, '0, 0, w);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_scan_sched.md
# seq_scan_sched

Scheduler and serializer that shares a single serial pattern-detector engine between two parallel requesters. Each accepted word is shifted LSB-first through the engine, one bit per clock. The block counts how many times the programmed bit pattern occurs within that word and returns the count with the requester ID. It sits between word-oriented producers and the bit-serial sequence-detection datapath, replacing hand-driven serial stimulus on `x`.

## Interface
- `DATA_W`, 8, word width in bits (≥ `PAT_W`)
- `PAT_W`, 4, pattern length in bits (2..`DATA_W`)
- `PAT_RESET`, 4'b1101, pattern value after reset
- `CNT_W`, $clog2(`DATA_W`+1), match-count width (derived; not overridden)

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req0_valid`  in  1  requester 0 has a word
- `req0_data`  in  `DATA_W`  requester 0 word
- `req0_ready`  out  1  requester 0 word accepted this cycle
- `req1_valid`, `req1_data`, `req1_ready`  same as above, for requester 1
- `pat_load`  in  1  latch `pat_in` as the new pattern
- `pat_in`  in  `PAT_W`  pattern; MSB = oldest bit
- `busy`  out  1  word in flight (states SHIFT or DONE)
- `x_bit`  out  1  serial bit presented to the engine (registered)
- `y`  out  1  match strobe for the bit on `x_bit` (registered)
- `done`  out  1  one-cycle result strobe
- `done_id`  out  1  requester that owns the result
- `match_cnt`  out  `CNT_W`  number of matches in the finished word

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE:
  - `req*_ready` is combinational: only the arbiter winner sees ready=1, and only when that requester's valid=1.
  - A handshake (valid & ready) at edge E captures the data, the ID and `last_grant`. It clears `hist`, `idx`, `cnt` and `seen`, and moves to SHIFT.
- Arbitration (`SEQ_SCHED_RR_EN` defined):
  - When both requesters are valid, the requester ≠ `last_grant` wins.
  - When one requester is valid, it wins.
  - `last_grant` resets to 1, so requester 0 wins the first tie.
- SHIFT, on each edge, with b = data[`idx`]:
  - `hist` ← {`hist`[`PAT_W`-2:0], b}
  - `x_bit` ← b
  - m = ({`hist`[`PAT_W`-2:0], b} == `pat`) && (`idx`+1 ≥ `PAT_W`)
  - `y` ← m; `cnt` ← `cnt` + m; `idx` ← `idx` + 1
  - After the edge at `idx` = `DATA_W`-1, go to DONE.
- Match semantics:
  - Overlapping matches count.
  - History never spans two words; it is cleared at each handshake.
- DONE (one cycle):
  - `done`=1; `match_cnt` = final count; `done_id` = owner.
  - The next edge returns to IDLE.
  - `y` and `x_bit` hold the values for the last bit during DONE.
- Pattern register:
  - `pat_load` in IDLE latches `pat_in` at the edge.
  - `pat_load` during SHIFT or DONE is ignored, and the pattern stays unchanged.
  - If `pat_load` and a handshake occur in the same IDLE cycle, both take effect. The new pattern applies to that word.
- Registered outputs outside DONE: `done`=0. `match_cnt` and `done_id` hold their last values.
- Counter arithmetic is unsigned and cannot overflow, because the maximum match count is `DATA_W`-`PAT_W`+1.
- Reset mid-operation: everything returns to reset values, the in-flight word is dropped, and no `done` is produced.
- Reset values: state=IDLE, `busy`=0, `x_bit`=0, `y`=0, `done`=0, `done_id`=0, `match_cnt`=0, `pat`=`PAT_RESET`, `last_grant`=1. `req*_ready` follows the IDLE arbitration.

## Timing
- Handshake at edge E:
  - `busy`=1 from E.
  - Bit k appears on `x_bit`/`y` after edge E+1+k.
  - `done`=1 in the cycle after edge E+`DATA_W`.
  - The next handshake can occur at edge E+`DATA_W`+2 at the earliest.
- Throughput: one word per `DATA_W`+2 cycles.
- `ready` is never asserted outside IDLE.

## Configuration
- `SEQ_SCHED_RR_EN` defined: round-robin arbitration as described above.
- `SEQ_SCHED_RR_EN` undefined: fixed priority. Requester 0 always wins a tie; `last_grant` is still recorded but not used by the arbiter.

## Structure
- Shared package `seq_sched_pkg`:
  - state enum (IDLE/SHIFT/DONE)
  - `PAT_RESET` default
  - requester-ID constants `REQ0`/`REQ1`
- Sub-module `seq_match_engine`:
  - contains `hist`, the pattern register, the compare and the `seen` qualification
  - inputs: `clk`, `rst`, `clr`, `shift_en`, `bit`, `pat_load`, `pat_in`
  - output: match `m`
- The scheduler top holds the FSM, the arbiter, `idx`, `cnt` and the output registers.

## Test plan
- Scenario 1: reset; `pat`=1101; req0 sends 8'b1011_0110 (bits 0,1,1,0,1,1,0,1) → `y` pulses after bits 4 and 7; `done`=1 with `match_cnt`=2 and `done_id`=0 on cycle E+9.
- Scenario 2: load `pat`=1111; req1 sends 8'hFF → 5 overlapping matches; `match_cnt`=5, `done_id`=1.
- Scenario 3: req0 sends 8'h00 with `pat`=1101 → `match_cnt`=0 and `y` never high; `done` still pulses for exactly 1 cycle.
- Scenario 4: both requesters hold valid with three words each.
  - RR build: grants alternate 0,1,0,1,0,1.
  - Build without the macro: req0 is granted three times, then req1.
- Scenario 5: `pat_load` with `pat_in`=0000 asserted during SHIFT → ignored; the current word counts against 1101, and the next word also uses 1101.
- Scenario 6: assert `rst` at bit 3 of a word → all outputs return to reset values immediately; no `done` is produced; after release, req0 is accepted on the first valid cycle.
